// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants and types for the int_ctrl interrupt controller.
//   - register word offsets within the 16-byte window (Addr[3:2])
//   - arbitration state machine encoding
//   - STATUS register field positions
package int_ctrl_pkg;

  // Register select values taken from Addr[3:2]
  localparam logic [1:0] OFF_PEND   = 2'd0;
  localparam logic [1:0] OFF_ENABLE = 2'd1;
  localparam logic [1:0] OFF_EOI    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // Width of the in-service line index
  localparam int unsigned IDX_W = 3;

  // STATUS layout: {busy, zeros, idx}
  localparam int unsigned STATUS_BUSY_BIT = 31;
  localparam int unsigned STATUS_IDX_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// irq_sync: per-line 2-flop synchronizer followed by a third flop for rising
// edge detection on asynchronous interrupt requests.
//   clk, rst : system clock, async active-high reset
//   irq      : asynchronous request lines
//   edge_c   : one-cycle pulse per synchronized rising edge (combinational)
module irq_sync #(
  parameter int unsigned NIRQ = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  output logic [NIRQ-1:0] edge_c
);

  logic [NIRQ-1:0] sync1_q;
  logic [NIRQ-1:0] sync2_q;
  logic [NIRQ-1:0] sync3_q;

  // Synchronizer chain plus edge-detect history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Rising edge only, so a held-high line fires once
  assign edge_c = sync2_q & ~sync3_q;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped fixed-priority interrupt controller.
// Snoops CPU loads/stores on Addr/BUS to a 16-byte window at BASE:
//   +0x0 PEND (R/W1C), +0x4 ENABLE (R/W), +0x8 EOI (W), +0xC STATUS (R).
// Ports:
//   clk, rst          : system clock, async active-high reset
//   irq[NIRQ]         : asynchronous peripheral requests (rising edge)
//   Addr, BUS         : snooped CPU address and write data
//   Memread, Memwrite : CPU read strobe, write strobe (any non-zero writes)
//   bus_out, bus_oe   : combinational read data and its drive enable
//   INTin, INTnum     : registered interrupt request and vector to the CPU
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NIRQ     = 8,
  parameter logic [31:0] BASE     = 32'hA000_0000,
  parameter logic [31:0] VEC_BASE = 32'd32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic [31:0]     Addr,
  input  logic [31:0]     BUS,
  input  logic            Memread,
  input  logic [1:0]      Memwrite,
  output logic [31:0]     bus_out,
  output logic            bus_oe,
  output logic            INTin,
  output logic [31:0]     INTnum
);

  state_e           state_q, state_d;
  logic [NIRQ-1:0]  pend_q, pend_d;
  logic [NIRQ-1:0]  enable_q, enable_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             intin_q, intin_d;
  logic [31:0]      intnum_q, intnum_d;

  logic [NIRQ-1:0]  irq_edge;
  logic [NIRQ-1:0]  claim_req;
  logic [IDX_W-1:0] sel;
  logic             any_req;
  logic             claim;

  logic             hit;
  logic [1:0]       reg_sel;
  logic             wr_en;
  logic             pend_we, enable_we, eoi_we;
  logic [31:0]      rdata;

  // Low address bits and upper data bits carry no information here
  logic             unused_ok;
  assign unused_ok = ^{Addr[1:0], BUS[31:NIRQ]};

  irq_sync #(.NIRQ(NIRQ)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .irq    (irq),
    .edge_c (irq_edge)
  );

  // Window decode
  assign hit       = (Addr[31:4] == BASE[31:4]);
  assign reg_sel   = Addr[3:2];
  assign wr_en     = hit && (Memwrite != 2'b00);
  assign pend_we   = wr_en && (reg_sel == OFF_PEND);
  assign enable_we = wr_en && (reg_sel == OFF_ENABLE);
  assign eoi_we    = wr_en && (reg_sel == OFF_EOI);

  // Fixed priority: lowest enabled pending index wins
  always_comb begin
    claim_req = pend_q & enable_q;
    any_req   = |claim_req;
    sel       = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (claim_req[i]) sel = IDX_W'(i);
    end
  end

  // Arbitration FSM: next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    intin_d  = intin_q;
    intnum_d = intnum_q;
    idx_d    = idx_q;
    claim    = 1'b0;
    case (state_q)
      IDLE: begin
        intin_d = 1'b0;
        if (any_req) begin
          claim    = 1'b1;
          idx_d    = sel;
          intin_d  = 1'b1;
          intnum_d = VEC_BASE + 32'(sel);
          state_d  = REQ;
        end
      end
      REQ: begin
        intin_d = 1'b1;
        if (eoi_we) begin
          intin_d = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        // Guaranteed low cycle between back-to-back interrupts
        intin_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        intin_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Pending/enable update; new edges are applied last so the set wins
  always_comb begin
    pend_d   = pend_q;
    enable_d = enable_q;
    if (pend_we)   pend_d = pend_d & ~BUS[NIRQ-1:0];
    if (claim)     pend_d = pend_d & ~(NIRQ'(1) << sel);
    pend_d = pend_d | irq_edge;
    if (enable_we) enable_d = BUS[NIRQ-1:0];
  end

  // State and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      enable_q <= '0;
      idx_q    <= '0;
      intin_q  <= 1'b0;
      intnum_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      enable_q <= enable_d;
      idx_q    <= idx_d;
      intin_q  <= intin_d;
      intnum_q <= intnum_d;
    end
  end

  // Zero-latency read mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      OFF_PEND:   rdata = 32'(pend_q);
      OFF_ENABLE: rdata = 32'(enable_q);
      OFF_STATUS: begin
        rdata[STATUS_BUSY_BIT]              = (state_q == REQ);
        rdata[STATUS_IDX_LSB +: IDX_W]      = idx_q;
      end
      default:    rdata = '0;
    endcase
  end

  // Reset forces the bus driver off immediately
  assign bus_oe  = Memread && hit && !rst;
  assign bus_out = bus_oe ? rdata : '0;

  assign INTin  = intin_q;
  assign INTnum = intnum_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl.
module tb_int_ctrl;

  localparam logic [31:0] BASE = 32'hA000_0000;
  localparam logic [31:0] A_PEND   = BASE + 32'h0;
  localparam logic [31:0] A_ENABLE = BASE + 32'h4;
  localparam logic [31:0] A_EOI    = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic [31:0] Addr;
  logic [31:0] BUS;
  logic        Memread;
  logic [1:0]  Memwrite;
  logic [31:0] bus_out;
  logic        bus_oe;
  logic        INTin;
  logic [31:0] INTnum;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_data;
  logic        rd_oe;

  int_ctrl #(.NIRQ(8), .BASE(BASE), .VEC_BASE(32'd32)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .Addr     (Addr),
    .BUS      (BUS),
    .Memread  (Memread),
    .Memwrite (Memwrite),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .INTin    (INTin),
    .INTnum   (INTnum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr     = a;
    BUS      = d;
    Memwrite = 2'b01;
    step();
    Memwrite = 2'b00;
    Addr     = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic oe);
    Addr    = a;
    Memread = 1'b1;
    #1;
    d  = bus_out;
    oe = bus_oe;
    Memread = 1'b0;
    Addr    = 32'h0;
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; Addr = 32'h0; BUS = 32'h0;
    Memread = 1'b0; Memwrite = 2'b00;
    step(); step();
    chk("reset_intin", 32'(INTin), 32'h0);
    chk("reset_intnum", INTnum, 32'h0);
    rst = 1'b0;
    step();
    rd(A_PEND, rd_data, rd_oe);
    chk("reset_pend", rd_data, 32'h0);

    // 1: single line latency
    wr(A_ENABLE, 32'h01);
    irq[0] = 1'b1;
    step();
    chk("t1_intin_n", 32'(INTin), 32'h0);
    step(); step();
    chk("t1_intin_n2", 32'(INTin), 32'h0);
    rd(A_PEND, rd_data, rd_oe);
    chk("t1_pend_n2", rd_data, 32'h01);
    step();
    chk("t1_intin_n3", 32'(INTin), 32'h1);
    chk("t1_intnum", INTnum, 32'd32);
    rd(A_PEND, rd_data, rd_oe);
    chk("t1_pend_claimed", rd_data, 32'h00);
    rd(A_STATUS, rd_data, rd_oe);
    chk("t1_status", rd_data, 32'h8000_0000);
    irq[0] = 1'b0;
    wr(A_EOI, 32'h0);
    chk("t1_eoi_low", 32'(INTin), 32'h0);
    step();
    chk("t1_gap_low", 32'(INTin), 32'h0);
    chk("t1_intnum_held", INTnum, 32'd32);

    // 2: priority between simultaneous lines
    wr(A_ENABLE, 32'hFF);
    irq = 8'b0010_0100;
    step(); step(); step(); step();
    chk("t2_intin", 32'(INTin), 32'h1);
    chk("t2_intnum", INTnum, 32'd34);
    rd(A_PEND, rd_data, rd_oe);
    chk("t2_pend", rd_data, 32'h20);
    wr(A_EOI, 32'h0);
    chk("t2_eoi_low", 32'(INTin), 32'h0);
    step();
    chk("t2_gap_low", 32'(INTin), 32'h0);
    step();
    chk("t2_second_intin", 32'(INTin), 32'h1);
    chk("t2_second_intnum", INTnum, 32'd37);
    wr(A_EOI, 32'h0);
    step(); step(); step();
    chk("t2_level_no_retrigger", 32'(INTin), 32'h0);
    rd(A_PEND, rd_data, rd_oe);
    chk("t2_pend_empty", rd_data, 32'h00);
    irq = 8'h00;

    // 3: masked pend, W1C and edge/W1C collision
    wr(A_ENABLE, 32'h00);
    irq[3] = 1'b1;
    step(); step(); step();
    irq[3] = 1'b0;
    step();
    rd(A_PEND, rd_data, rd_oe);
    chk("t3_pend_masked", rd_data, 32'h08);
    chk("t3_no_intin", 32'(INTin), 32'h0);
    wr(A_PEND, 32'h08);
    rd(A_PEND, rd_data, rd_oe);
    chk("t3_w1c", rd_data, 32'h00);
    step(); step();
    irq[3] = 1'b1;
    step(); step();
    wr(A_PEND, 32'h08);
    rd(A_PEND, rd_data, rd_oe);
    chk("t3_set_wins", rd_data, 32'h08);
    irq[3] = 1'b0;
    step();
    wr(A_PEND, 32'hFF);
    rd(A_PEND, rd_data, rd_oe);
    chk("t3_cleared", rd_data, 32'h00);

    // 4: re-trigger of the in-service line
    wr(A_ENABLE, 32'h02);
    irq[1] = 1'b1;
    step(); step(); step(); step();
    chk("t4_intnum", INTnum, 32'd33);
    irq[1] = 1'b0;
    step(); step(); step();
    irq[1] = 1'b1;
    step(); step(); step();
    rd(A_PEND, rd_data, rd_oe);
    chk("t4_repend", rd_data, 32'h02);
    chk("t4_still_req", 32'(INTin), 32'h1);
    wr(A_EOI, 32'h0);
    chk("t4_eoi_low", 32'(INTin), 32'h0);
    step(); step();
    chk("t4_reassert", 32'(INTin), 32'h1);
    chk("t4_reassert_num", INTnum, 32'd33);
    irq[1] = 1'b0;
    wr(A_EOI, 32'h0);
    step(); step();

    // 6: STATUS read during REQ and out-of-window read
    wr(A_ENABLE, 32'h40);
    irq[6] = 1'b1;
    step(); step(); step(); step();
    chk("t6_intnum", INTnum, 32'd38);
    rd(A_STATUS, rd_data, rd_oe);
    chk("t6_status_oe", 32'(rd_oe), 32'h1);
    chk("t6_status", rd_data, 32'h8000_0006);
    rd(A_EOI, rd_data, rd_oe);
    chk("t6_eoi_read", rd_data, 32'h0);
    rd(BASE + 32'h10, rd_data, rd_oe);
    chk("t6_miss_oe", 32'(rd_oe), 32'h0);
    wr(A_ENABLE, 32'h00);
    step();
    chk("t6_no_retract", 32'(INTin), 32'h1);
    rd(A_ENABLE, rd_data, rd_oe);
    chk("t6_enable_rd", rd_data, 32'h00);

    // 5: reset while in REQ
    irq = 8'h00;
    wr(A_ENABLE, 32'hFF);
    Addr = A_STATUS;
    Memread = 1'b1;
    #1;
    chk("t5_oe_before", 32'(bus_oe), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rst_intin", 32'(INTin), 32'h0);
    chk("t5_rst_intnum", INTnum, 32'h0);
    chk("t5_rst_oe", 32'(bus_oe), 32'h0);
    Memread = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    rd(A_PEND, rd_data, rd_oe);
    chk("t5_pend", rd_data, 32'h0);
    rd(A_ENABLE, rd_data, rd_oe);
    chk("t5_enable", rd_data, 32'h0);
    rd(A_STATUS, rd_data, rd_oe);
    chk("t5_status", rd_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller that sits directly upstream of the CPU's interrupt inputs. It collects up to eight asynchronous peripheral request lines and latches rising edges as pending bits. It arbitrates by fixed priority and drives the CPU's `INTin`/`INTnum` pair. The CPU programs the block and retires each interrupt through ordinary loads and stores on the same `Addr`/`BUS`/`Memread`/`Memwrite` signals it uses for memory; the block snoops those signals.

## Interface
- `NIRQ`, 8: number of request lines, 1..8.
- `BASE`, 32'hA000_0000: register window base address, 16-byte aligned.
- `VEC_BASE`, 32: `INTnum` value for line 0; line i reports `VEC_BASE + i`.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `irq`  in  NIRQ  asynchronous peripheral requests; a rising edge requests service.
- `Addr`  in  32  CPU address, snooped.
- `BUS`  in  32  CPU data bus, snooped as write data.
- `Memread`  in  1  CPU read strobe.
- `Memwrite`  in  2  CPU write strobe; any non-zero value is a full 32-bit write.
- `bus_out`  out  32  read data; the top level drives it onto `BUS` when `bus_oe` is high.
- `bus_oe`  out  1  high while `Memread` is high and `Addr` hits the window.
- `INTin`  out  1  interrupt request to the CPU.
- `INTnum`  out  32  vector of the interrupt in service.

## Operation
- **Window decode**
  - Hit when `Addr[31:4] == BASE[31:4]`; `Addr[3:2]` selects the register.
  - 0x0 PEND: read returns pending bits, zero-extended; write-1-to-clear.
  - 0x4 ENABLE: read/write, bit i enables line i.
  - 0x8 EOI: write of any value ends service; reads return 0.
  - 0xC STATUS: read-only, `{busy[31], 28'b0, idx[2:0]}`; `busy` is high in REQ.
  - Bits at and above `NIRQ` read 0 and ignore writes. Writes to read-only registers are ignored.
- **Input capture**
  - Each `irq` bit passes through a 2-flop synchronizer, then a third flop for edge detection.
  - `edge = s2 & ~s3` sets `pend[i]`.
  - Level-high inputs do not re-trigger.
- **State machine** (3 states)
  - IDLE: when `pend & enable` is non-zero, select the lowest set index, clear its pend bit, latch `idx`, and go to REQ.
  - REQ: `INTin`=1, `INTnum=VEC_BASE+idx`. Hold until an EOI write is seen, then go to GAP.
  - GAP: one cycle with `INTin`=0, then go to IDLE. This guarantees the CPU sees a low level between two interrupts.
- **Collisions**
  - An edge and a W1C on the same bit in the same cycle: the set wins.
  - The IDLE claim-clear and an edge on the same bit in the same cycle: the set wins, so the line is re-queued.
  - Clearing ENABLE or PEND while in REQ does not retract the interrupt in service.
  - An edge on the in-service line while in REQ sets pend again.
- **Reset**
  - `rst` takes effect at any time, including mid-REQ.
  - It clears all synchronizer flops, `pend`, `enable` and `idx`, and puts the state machine in IDLE.
  - All outputs reset to 0.

## Timing
- Input-to-request latency: `irq` first sampled high at edge n → `pend` set after edge n+2 → `INTin` high after edge n+3 (from IDLE with the line enabled).
- `INTin`, `INTnum` and STATUS are registered. `INTnum` holds its value through GAP and IDLE until the next claim.
- Register writes take effect at the edge where `Memwrite != 0`.
- An EOI write at edge k: `INTin` is low after edge k. The earliest next `INTin` is high after edge k+2.
- `bus_oe`/`bus_out` are combinational from `Memread`/`Addr` and current register state. There is zero-cycle read latency, matching memory reads.

## Structure
- Package `int_ctrl_pkg`:
  - register offsets `OFF_PEND`/`OFF_ENABLE`/`OFF_EOI`/`OFF_STATUS`;
  - state enum `IDLE`/`REQ`/`GAP`;
  - STATUS bit positions.
- Sub-module `irq_sync`: a `NIRQ`-wide 3-flop synchronizer and edge detector with async reset, outputting an `edge` vector.
- The top module holds decode, registers, the priority encoder and the FSM.

## Test plan
1. Reset, write ENABLE=0x01, pulse `irq[0]` at edge 10 → `INTin`=1 and `INTnum`=32 after edge 13; PEND reads 0x00.
2. ENABLE=0xFF, raise `irq[5]` and `irq[2]` together → `INTnum`=34. EOI → `INTin` low for one cycle, then `INTnum`=37.
3. ENABLE=0x00, pulse `irq[3]` → PEND=0x08 and no `INTin`. Write PEND=0x08 → PEND=0x00. Re-pulse the line so its edge lands in the same cycle as a W1C → PEND=0x08.
4. In REQ on line 1, re-pulse `irq[1]` → after EOI and GAP, `INTnum`=33 is asserted again.
5. Assert `rst` mid-REQ → `INTin`, `INTnum`, `bus_oe` go 0 immediately. PEND, ENABLE and STATUS read 0 after release.
6. Read `BASE`+0xC during REQ on line 6 → `bus_oe`=1, `bus_out`=0x8000_0006. Read address `BASE`+0x10 → `bus_oe`=0.
